// File: rtl/dmem_pkg.sv
// Shared types for the dmem_responder load/store target: access modes and FSM states.
package dmem_pkg;

    typedef enum logic [2:0] {
        MM_B  = 3'b000,
        MM_H  = 3'b001,
        MM_W  = 3'b010,
        MM_BU = 3'b100,
        MM_HU = 3'b101
    } mem_mode_t;

    typedef enum logic [1:0] {
        S_IDLE,
        S_BUSY,
        S_RESP
    } dmem_state_t;

endpackage

// File: rtl/dmem_lane_align.sv
// Byte-lane steering for one 32-bit word: store mask/shift, load extraction/extension, misalign check.
module dmem_lane_align
    import dmem_pkg::*;
(
    input  logic [2:0]  mode_i,
    input  logic [1:0]  off_i,
    input  logic [31:0] wdata_i,
    input  logic [31:0] rword_i,
    output logic [3:0]  be_o,
    output logic [31:0] wdata_o,
    output logic [31:0] rdata_o,
    output logic        err_o
);

    logic [15:0] sh;

    always_comb begin
        // Selected lane moved down to bit 0; only the low half is ever needed.
        sh      = 16'(rword_i >> {off_i, 3'b000});
        wdata_o = wdata_i << {off_i, 3'b000};
        be_o    = 4'b0000;
        rdata_o = '0;
        err_o   = 1'b0;
        case (mode_i)
            MM_B: begin
                be_o    = 4'b0001 << off_i;
                rdata_o = {{24{sh[7]}}, sh[7:0]};
            end
            MM_BU: begin
                be_o    = 4'b0001 << off_i;
                rdata_o = {24'b0, sh[7:0]};
            end
            MM_H, MM_HU: begin
                if (off_i == 2'd3) begin
                    err_o = 1'b1;
                end else begin
                    be_o    = 4'b0011 << off_i;
                    rdata_o = (mode_i == MM_H) ? {{16{sh[15]}}, sh[15:0]} : {16'b0, sh[15:0]};
                end
            end
            MM_W: begin
                if (off_i != 2'd0) begin
                    err_o = 1'b1;
                end else begin
                    be_o    = 4'b1111;
                    rdata_o = rword_i;
                end
            end
            default: err_o = 1'b1;
        endcase
    end

endmodule

// File: rtl/dmem_responder.sv
// Multi-cycle data-memory target on a valid/ready handshake, one request in flight.
// Define DMEM_STATS_EN to add ld_count/st_count/err_count completion counters.
module dmem_responder
    import dmem_pkg::*;
#(
    parameter int WIDTH   = 32,   // data lanes are 32 bits wide
    parameter int DEPTH   = 1024,
    parameter int LATENCY = 2
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             req_valid,
    output logic             req_ready,
    input  logic             req_we,
    input  logic [2:0]       req_mode,
    input  logic [WIDTH-1:0] req_addr,
    input  logic [WIDTH-1:0] req_wdata,
    output logic             rsp_valid,
    input  logic             rsp_ready,
    output logic [WIDTH-1:0] rsp_rdata,
    output logic             rsp_err
`ifdef DMEM_STATS_EN
    ,
    output logic [31:0]      ld_count,
    output logic [31:0]      st_count,
    output logic [31:0]      err_count
`endif
);

    localparam int AW     = $clog2(DEPTH);
    localparam int CW     = (LATENCY > 2) ? $clog2(LATENCY) : 1;
    localparam bit DIRECT = (LATENCY == 1);

    dmem_state_t      state_q, state_d;
    logic [CW-1:0]    cnt_q, cnt_d;
    logic [WIDTH-1:0] rdata_q, rdata_d;
    logic             err_q, err_d;

    logic             we_q;
    logic [2:0]       mode_q;
    logic [WIDTH-1:0] addr_q, wdata_q;

    logic [WIDTH-1:0] mem [DEPTH];

    logic             accept, do_acc, wr_en;
    logic             acc_we;
    logic [2:0]       acc_mode;
    logic [WIDTH-1:0] acc_addr, acc_wdata;
    logic [AW-1:0]    idx;
    logic [3:0]       be;
    logic [31:0]      wsh, lrd;
    logic             lerr;

    // With single-cycle latency the access happens on the accept edge, so it
    // must see the live request rather than the latched copy.
    assign acc_we    = DIRECT ? req_we    : we_q;
    assign acc_mode  = DIRECT ? req_mode  : mode_q;
    assign acc_addr  = DIRECT ? req_addr  : addr_q;
    assign acc_wdata = DIRECT ? req_wdata : wdata_q;
    assign idx       = acc_addr[AW+1:2];

    logic unused_addr_hi;
    assign unused_addr_hi = ^acc_addr[WIDTH-1:AW+2];

    dmem_lane_align u_align (
        .mode_i  (acc_mode),
        .off_i   (acc_addr[1:0]),
        .wdata_i (acc_wdata),
        .rword_i (mem[idx]),
        .be_o    (be),
        .wdata_o (wsh),
        .rdata_o (lrd),
        .err_o   (lerr)
    );

    assign accept    = (state_q == S_IDLE) && req_valid;
    assign req_ready = (state_q == S_IDLE);
    assign rsp_valid = (state_q == S_RESP);
    assign rsp_rdata = rdata_q;
    assign rsp_err   = err_q;

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        rdata_d = rdata_q;
        err_d   = err_q;
        do_acc  = 1'b0;
        case (state_q)
            S_IDLE: begin
                if (req_valid) begin
                    if (DIRECT) begin
                        do_acc  = 1'b1;
                        state_d = S_RESP;
                    end else begin
                        cnt_d   = CW'(LATENCY - 1);
                        state_d = S_BUSY;
                    end
                end
            end
            S_BUSY: begin
                cnt_d = cnt_q - CW'(1);
                if (cnt_q == CW'(1)) begin
                    do_acc  = 1'b1;
                    state_d = S_RESP;
                end
            end
            S_RESP: begin
                if (rsp_ready) state_d = S_IDLE;
            end
            default: state_d = S_IDLE;
        endcase
        if (do_acc) begin
            err_d   = lerr;
            rdata_d = (acc_we || lerr) ? '0 : lrd;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            state_q <= S_IDLE;
            cnt_q   <= '0;
            rdata_q <= '0;
            err_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            rdata_q <= rdata_d;
            err_q   <= err_d;
        end
    end

    always_ff @(posedge clk) begin
        if (accept) begin
            we_q    <= req_we;
            mode_q  <= req_mode;
            addr_q  <= req_addr;
            wdata_q <= req_wdata;
        end
    end

    // Gated by rst so a reset landing on the access edge aborts the write.
    assign wr_en = do_acc && acc_we && !lerr && rst;

    always_ff @(posedge clk) begin
        for (int b = 0; b < 4; b++) begin
            if (wr_en && be[b]) mem[idx][8*b +: 8] <= wsh[8*b +: 8];
        end
    end

`ifdef DMEM_STATS_EN
    logic [31:0] ld_cnt_q, st_cnt_q, err_cnt_q;
    logic        rsp_hs;

    assign rsp_hs    = rsp_valid && rsp_ready;
    assign ld_count  = ld_cnt_q;
    assign st_count  = st_cnt_q;
    assign err_count = err_cnt_q;

    always_ff @(posedge clk) begin
        if (!rst) begin
            ld_cnt_q  <= '0;
            st_cnt_q  <= '0;
            err_cnt_q <= '0;
        end else if (rsp_hs) begin
            if (err_q)      err_cnt_q <= err_cnt_q + 32'd1;
            else if (we_q)  st_cnt_q  <= st_cnt_q + 32'd1;
            else            ld_cnt_q  <= ld_cnt_q + 32'd1;
        end
    end
`endif

endmodule

// File: tb/tb_dmem_responder.sv
// Scoreboard bench for dmem_responder: expected responses queued at issue, checked at completion.
module tb_dmem_responder;

    localparam int LAT = 2;
    localparam int DEP = 1024;

    typedef struct {
        logic        we;
        logic [2:0]  mode;
        logic [31:0] addr;
        logic [31:0] wdata;
        logic [31:0] er;
        logic        ee;
    } txn_t;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic        req_valid = 1'b0;
    logic        req_ready;
    logic        req_we = 1'b0;
    logic [2:0]  req_mode = 3'b010;
    logic [31:0] req_addr = '0;
    logic [31:0] req_wdata = '0;
    logic        rsp_valid;
    logic        rsp_ready = 1'b0;
    logic [31:0] rsp_rdata;
    logic        rsp_err;
`ifdef DMEM_STATS_EN
    logic [31:0] ld_count, st_count, err_count;
`endif

    int          total = 0;
    int          bad = 0;
    logic [32:0] exp_q[$];
    logic [32:0] exp;
    int          got_lat;
    bit          tmo;
    logic [31:0] got_rd;
    logic        got_err;

    always #5 clk = ~clk;

    dmem_responder #(.WIDTH(32), .DEPTH(DEP), .LATENCY(LAT)) dut (
        .clk       (clk),
        .rst       (rst),
        .req_valid (req_valid),
        .req_ready (req_ready),
        .req_we    (req_we),
        .req_mode  (req_mode),
        .req_addr  (req_addr),
        .req_wdata (req_wdata),
        .rsp_valid (rsp_valid),
        .rsp_ready (rsp_ready),
        .rsp_rdata (rsp_rdata),
        .rsp_err   (rsp_err)
`ifdef DMEM_STATS_EN
        ,
        .ld_count  (ld_count),
        .st_count  (st_count),
        .err_count (err_count)
`endif
    );

    function automatic txn_t mk(input logic we, input logic [2:0] mode, input logic [31:0] addr,
                                input logic [31:0] wdata, input logic [31:0] er, input logic ee);
        txn_t t;
        t.we = we; t.mode = mode; t.addr = addr; t.wdata = wdata; t.er = er; t.ee = ee;
        return t;
    endfunction

    task automatic drive(input txn_t t);
        req_we    = t.we;
        req_mode  = t.mode;
        req_addr  = t.addr;
        req_wdata = t.wdata;
    endtask

    // Issue one request, queue its expected response, and measure accept-to-rsp_valid cycles.
    task automatic send(input txn_t t);
        int n;
        exp_q.push_back({t.ee, t.er});
        drive(t);
        req_valid = 1'b1;
        n = 0;
        while (!req_ready && n < 50) begin
            @(posedge clk); #1; n++;
        end
        @(posedge clk); #1;
        req_valid = 1'b0;
        got_lat = 1;
        while (!rsp_valid && got_lat < 50) begin
            @(posedge clk); #1; got_lat++;
        end
        tmo = !rsp_valid;
    endtask

    task automatic take();
        got_rd    = rsp_rdata;
        got_err   = rsp_err;
        rsp_ready = 1'b1;
        @(posedge clk); #1;
        rsp_ready = 1'b0;
    endtask

    task automatic test_reset();
        rst = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        total++; if (req_ready !== 1'b1) begin bad++; $display("FAIL reset_req_ready: got=%b want=1", req_ready); end
        total++; if (rsp_valid !== 1'b0) begin bad++; $display("FAIL reset_rsp_valid: got=%b want=0", rsp_valid); end
        total++; if (rsp_err !== 1'b0) begin bad++; $display("FAIL reset_rsp_err: got=%b want=0", rsp_err); end
        total++; if (rsp_rdata !== 32'h0) begin bad++; $display("FAIL reset_rsp_rdata: got=%h want=0", rsp_rdata); end
        rst = 1'b1;
    endtask

    task automatic test_word();
        txn_t t[2];
        t[0] = mk(1'b1, 3'b010, 32'h10, 32'hDEADBEEF, 32'h0, 1'b0);
        t[1] = mk(1'b0, 3'b010, 32'h10, 32'h0, 32'hDEADBEEF, 1'b0);
        foreach (t[i]) begin
            send(t[i]); take(); exp = exp_q.pop_front();
            total++; if (tmo || got_lat != LAT) begin bad++; $display("FAIL word_lat[%0d]: got=%0d want=%0d", i, got_lat, LAT); end
            total++; if ({got_err, got_rd} !== exp) begin bad++; $display("FAIL word_rsp[%0d]: got err=%b rdata=%h want err=%b rdata=%h", i, got_err, got_rd, exp[32], exp[31:0]); end
        end
    endtask

    task automatic test_byte();
        txn_t t[5];
        t[0] = mk(1'b1, 3'b010, 32'h20, 32'h0, 32'h0, 1'b0);
        t[1] = mk(1'b1, 3'b000, 32'h21, 32'h80, 32'h0, 1'b0);
        t[2] = mk(1'b0, 3'b010, 32'h20, 32'h0, 32'h00008000, 1'b0);
        t[3] = mk(1'b0, 3'b000, 32'h21, 32'h0, 32'hFFFFFF80, 1'b0);
        t[4] = mk(1'b0, 3'b100, 32'h21, 32'h0, 32'h00000080, 1'b0);
        foreach (t[i]) begin
            send(t[i]); take(); exp = exp_q.pop_front();
            total++; if (tmo || got_lat != LAT) begin bad++; $display("FAIL byte_lat[%0d]: got=%0d want=%0d", i, got_lat, LAT); end
            total++; if ({got_err, got_rd} !== exp) begin bad++; $display("FAIL byte_rsp[%0d]: got err=%b rdata=%h want err=%b rdata=%h", i, got_err, got_rd, exp[32], exp[31:0]); end
        end
    endtask

    task automatic test_half();
        txn_t t[8];
        t[0] = mk(1'b1, 3'b010, 32'h30, 32'h0, 32'h0, 1'b0);
        t[1] = mk(1'b1, 3'b001, 32'h32, 32'h8001, 32'h0, 1'b0);
        t[2] = mk(1'b0, 3'b001, 32'h32, 32'h0, 32'hFFFF8001, 1'b0);
        t[3] = mk(1'b0, 3'b101, 32'h32, 32'h0, 32'h00008001, 1'b0);
        t[4] = mk(1'b0, 3'b001, 32'h33, 32'h0, 32'h0, 1'b1);
        t[5] = mk(1'b1, 3'b001, 32'h31, 32'h1234, 32'h0, 1'b0);
        t[6] = mk(1'b0, 3'b010, 32'h30, 32'h0, 32'h80123400, 1'b0);
        t[7] = mk(1'b0, 3'b101, 32'h31, 32'h0, 32'h00001234, 1'b0);
        foreach (t[i]) begin
            send(t[i]); take(); exp = exp_q.pop_front();
            total++; if (tmo || got_lat != LAT) begin bad++; $display("FAIL half_lat[%0d]: got=%0d want=%0d", i, got_lat, LAT); end
            total++; if ({got_err, got_rd} !== exp) begin bad++; $display("FAIL half_rsp[%0d]: got err=%b rdata=%h want err=%b rdata=%h", i, got_err, got_rd, exp[32], exp[31:0]); end
        end
    endtask

    task automatic test_errors();
        txn_t t[8];
        t[0] = mk(1'b1, 3'b010, 32'h40, 32'h11223344, 32'h0, 1'b0);
        t[1] = mk(1'b1, 3'b010, 32'h41, 32'hFFFFFFFF, 32'h0, 1'b1);
        t[2] = mk(1'b1, 3'b001, 32'h43, 32'hFFFF, 32'h0, 1'b1);
        t[3] = mk(1'b1, 3'b110, 32'h40, 32'hFFFFFFFF, 32'h0, 1'b1);
        t[4] = mk(1'b0, 3'b011, 32'h40, 32'h0, 32'h0, 1'b1);
        t[5] = mk(1'b0, 3'b111, 32'h40, 32'h0, 32'h0, 1'b1);
        t[6] = mk(1'b0, 3'b010, 32'h40, 32'h0, 32'h11223344, 1'b0);
        t[7] = mk(1'b0, 3'b010, 32'h40 + DEP * 4, 32'h0, 32'h11223344, 1'b0);
        foreach (t[i]) begin
            send(t[i]); take(); exp = exp_q.pop_front();
            total++; if (tmo || got_lat != LAT) begin bad++; $display("FAIL err_lat[%0d]: got=%0d want=%0d", i, got_lat, LAT); end
            total++; if ({got_err, got_rd} !== exp) begin bad++; $display("FAIL err_rsp[%0d]: got err=%b rdata=%h want err=%b rdata=%h", i, got_err, got_rd, exp[32], exp[31:0]); end
        end
    endtask

    task automatic test_backpressure();
        send(mk(1'b0, 3'b010, 32'h10, 32'h0, 32'hDEADBEEF, 1'b0));
        for (int c = 0; c < 5; c++) begin
            total++; if (rsp_valid !== 1'b1) begin bad++; $display("FAIL bp_valid[%0d]: got=%b want=1", c, rsp_valid); end
            total++; if (rsp_rdata !== 32'hDEADBEEF) begin bad++; $display("FAIL bp_rdata[%0d]: got=%h want=deadbeef", c, rsp_rdata); end
            total++; if (req_ready !== 1'b0) begin bad++; $display("FAIL bp_req_ready[%0d]: got=%b want=0", c, req_ready); end
            @(posedge clk); #1;
        end
        take(); exp = exp_q.pop_front();
        total++; if ({got_err, got_rd} !== exp) begin bad++; $display("FAIL bp_rsp: got err=%b rdata=%h want err=%b rdata=%h", got_err, got_rd, exp[32], exp[31:0]); end
    endtask

    task automatic test_reset_abort();
        drive(mk(1'b1, 3'b010, 32'h10, 32'hCAFEF00D, 32'h0, 1'b0));
        req_valid = 1'b1;
        @(posedge clk); #1;
        req_valid = 1'b0;
        total++; if (req_ready !== 1'b0 || rsp_valid !== 1'b0) begin bad++; $display("FAIL abort_busy: got ready=%b valid=%b want 0 0", req_ready, rsp_valid); end
        rst = 1'b0;
        @(posedge clk); #1;
        rst = 1'b1;
        total++; if (req_ready !== 1'b1 || rsp_valid !== 1'b0) begin bad++; $display("FAIL abort_idle: got ready=%b valid=%b want 1 0", req_ready, rsp_valid); end
        send(mk(1'b0, 3'b010, 32'h10, 32'h0, 32'hDEADBEEF, 1'b0));
        take(); exp = exp_q.pop_front();
        total++; if ({got_err, got_rd} !== exp) begin bad++; $display("FAIL abort_word: got err=%b rdata=%h want err=%b rdata=%h", got_err, got_rd, exp[32], exp[31:0]); end
    endtask

    task automatic test_back_to_back();
        txn_t t[4];
        int   i = 0, got = 0, cyc = 0, last_acc = -1;
        bit   acc_now, rsp_now;
        logic [31:0] rd;
        logic er;
        t[0] = mk(1'b0, 3'b010, 32'h10, 32'h0, 32'hDEADBEEF, 1'b0);
        t[1] = mk(1'b0, 3'b100, 32'h21, 32'h0, 32'h00000080, 1'b0);
        t[2] = mk(1'b0, 3'b001, 32'h32, 32'h0, 32'hFFFF8012, 1'b0);
        t[3] = mk(1'b0, 3'b010, 32'h40, 32'h0, 32'h11223344, 1'b0);
        foreach (t[k]) exp_q.push_back({t[k].ee, t[k].er});
        rsp_ready = 1'b1;
        drive(t[0]);
        req_valid = 1'b1;
        while (got < 4 && cyc < 200) begin
            acc_now = req_valid && req_ready;
            rsp_now = rsp_valid;
            rd = rsp_rdata;
            er = rsp_err;
            @(posedge clk); #1; cyc++;
            if (rsp_now) begin
                exp = exp_q.pop_front();
                total++; if ({er, rd} !== exp) begin bad++; $display("FAIL b2b_rsp[%0d]: got err=%b rdata=%h want err=%b rdata=%h", got, er, rd, exp[32], exp[31:0]); end
                got++;
            end
            if (acc_now) begin
                if (last_acc >= 0) begin
                    total++; if (cyc - last_acc != LAT + 1) begin bad++; $display("FAIL b2b_gap[%0d]: got=%0d want=%0d", i, cyc - last_acc, LAT + 1); end
                end
                last_acc = cyc;
                i++;
                if (i < 4) drive(t[i]);
                else req_valid = 1'b0;
            end
        end
        req_valid = 1'b0;
        rsp_ready = 1'b0;
        total++; if (got != 4) begin bad++; $display("FAIL b2b_count: got=%0d want=4", got); end
    endtask

    initial begin
        test_reset();
        test_word();
        test_byte();
        test_half();
        test_errors();
        test_backpressure();
        test_reset_abort();
        test_back_to_back();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
